// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions: digit count, blank pattern,
// hex segment-code table and the scan state type.
package seg_pkg;

    localparam int         SEG_NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK      = 8'h00;

    // IDLE until the first tick after reset, RUN while scanning.
    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_e;

    // Hex digit to segment pattern, bit0=a ... bit6=g, active-high.
    function automatic logic [6:0] seg_code(input logic [3:0] hex);
        logic [6:0] code;
        case (hex)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_hex_to_seg.sv
// Purely combinational hex-to-7-segment decoder (no dp, no state).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = seg_code(hex);

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner. Advances one digit per tick_1kHz, blanks
// all digits for GAP_CYCLES after each advance, and latches a new frame of
// data/dp_en/blank_lz only when the scan restarts at digit 0.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = SEG_NUM_DIGITS,
    parameter int GAP_CYCLES     = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk_50MHz,
    input  logic                    rst,
    input  logic                    tick_1kHz,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int             IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int             GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]     BLANK_OUT = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    scan_state_e                 state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic [4*NUM_DIGITS-1:0]     sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]       sh_dp_q, sh_dp_d;
    logic                        sh_lz_q, sh_lz_d;
    logic [NUM_DIGITS-1:0]       sel_q, sel_d;
    logic [7:0]                  seg_q, seg_d;
    logic                        frame_done_q, frame_done_d;

    logic [3:0]                  digit;
    logic                        upper_zero;
    logic [6:0]                  dec_seg;
    logic [7:0]                  seg_raw;
    logic                        drive;

    // Scan sequencing: the first tick after reset starts at digit 0, later
    // ticks advance; frame inputs are latched only when digit 0 is entered.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_lz_d      = sh_lz_q;
        frame_done_d = 1'b0;
        gap_d        = (gap_q != '0) ? gap_q - GW'(1) : '0;
        if (tick_1kHz) begin
            gap_d = GW'(GAP_CYCLES);
            if (state_q == SCAN_IDLE || idx_q == LAST_IDX) begin
                state_d   = SCAN_RUN;
                idx_d     = '0;
                sh_data_d = data;
                sh_dp_d   = dp_en;
                sh_lz_d   = blank_lz;
                // A real wrap, not the start-up tick, ends a frame.
                frame_done_d = (state_q == SCAN_RUN);
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Pick the digit being entered and see whether it and every digit above are zero.
    always_comb begin
        digit      = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                digit = sh_data_d[4*i +: 4];
            end
            if (IW'(i) >= idx_d && sh_data_d[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    hex_to_seg u_dec (
        .hex (digit),
        .seg (dec_seg)
    );

    // Next registered outputs: dark during the gap and before the first tick.
    always_comb begin
        drive   = (state_d == SCAN_RUN) && (gap_d == '0);
        seg_raw = {sh_dp_d[idx_d],
                   (sh_lz_d && idx_d != '0 && upper_zero) ? 7'h00 : dec_seg};
        sel_d   = drive ? (NUM_DIGITS'(1) << idx_d) : '0;
        seg_d   = drive ? (SEG_ACTIVE_LOW ? ~seg_raw : seg_raw) : BLANK_OUT;
    end

    // All state and outputs; reset abandons the frame at once.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q      <= SCAN_IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_lz_q      <= 1'b0;
            sel_q        <= '0;
            seg_q        <= BLANK_OUT;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_lz_q      <= sh_lz_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: default gap, zero gap and active-low variants
// driven from the same stimulus.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [31:0] data;
    logic [7:0]  dp_en;
    logic        blank_lz;

    logic [7:0]  sel,  seg;   logic fd;
    logic [7:0]  sel0, seg0;  logic fd0;
    logic [7:0]  sel_al, seg_al; logic fd_al;

    int total = 0;
    int bad   = 0;

    // {sel, seg, frame_done, active-low seg}
    logic [24:0] exp_q[$];

    localparam logic [7:0] SEGS_A [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    localparam logic [7:0] SEGS_B [8] = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
    localparam logic [7:0] SEGS_C [8] = '{8'h3F, 8'h6D, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    seg_scan #(.NUM_DIGITS(8), .GAP_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk_50MHz(clk), .rst(rst), .tick_1kHz(tick), .data(data), .dp_en(dp_en),
        .blank_lz(blank_lz), .sel(sel), .seg(seg), .frame_done(fd));

    seg_scan #(.NUM_DIGITS(8), .GAP_CYCLES(0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk_50MHz(clk), .rst(rst), .tick_1kHz(tick), .data(data), .dp_en(dp_en),
        .blank_lz(blank_lz), .sel(sel0), .seg(seg0), .frame_done(fd0));

    seg_scan #(.NUM_DIGITS(8), .GAP_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk_50MHz(clk), .rst(rst), .tick_1kHz(tick), .data(data), .dp_en(dp_en),
        .blank_lz(blank_lz), .sel(sel_al), .seg(seg_al), .frame_done(fd_al));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] g, input logic f);
        logic [7:0] g_al;
        g_al = (s == 8'h00) ? 8'hFF : ~g;
        exp_q.push_back({s, g, f, g_al});
    endtask

    task automatic pop_chk(input string tag);
        logic [24:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=queue_empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sel"}, 32'(sel), 32'(e[24:17]));
            chk({tag, "_seg"}, 32'(seg), 32'(e[16:9]));
            chk({tag, "_fd"}, 32'(fd), 32'(e[8]));
            chk({tag, "_al_seg"}, 32'(seg_al), 32'(e[7:0]));
            chk({tag, "_al_sel"}, 32'(sel_al), 32'(e[24:17]));
        end
    endtask

    // One tick: two blank cycles, then the digit; the zero-gap unit shows it at once.
    task automatic tick_chk(input string tag, input logic [7:0] sel_e,
                            input logic [7:0] seg_e, input logic fd_e);
        push(8'h00, 8'h00, fd_e);
        push(8'h00, 8'h00, 1'b0);
        push(sel_e, seg_e, 1'b0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        pop_chk({tag, "_g1"});
        chk({tag, "_nogap_sel"}, 32'(sel0), 32'(sel_e));
        chk({tag, "_nogap_seg"}, 32'(seg0), 32'(seg_e));
        chk({tag, "_nogap_fd"}, 32'(fd0), 32'(fd_e));
        @(posedge clk); #1;
        pop_chk({tag, "_g2"});
        @(posedge clk); #1;
        pop_chk({tag, "_dig"});
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'h00);
        chk({tag, "_seg"}, 32'(seg), 32'h00);
        chk({tag, "_fd"}, 32'(fd), 32'h0);
        chk({tag, "_al_seg"}, 32'(seg_al), 32'hFF);
        chk({tag, "_nogap_sel"}, 32'(sel0), 32'h00);
        chk({tag, "_nogap_fd"}, 32'(fd0), 32'h0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; data = 32'h7654_3210; dp_en = 8'h00; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_dark("reset");
        rst = 1'b0;
        // Dark until the first tick.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_dark("pre_tick");
        end

        // Plain frame, then the wrap tick.
        for (int i = 0; i < 8; i++)
            tick_chk("frame_a", 8'(1 << i), SEGS_A[i], 1'b0);
        tick_chk("wrap_a", 8'h01, 8'h3F, 1'b1);

        // Data changes mid-frame must wait for the next digit 0.
        data = 32'h0000_0000;
        for (int i = 1; i < 8; i++)
            tick_chk("old_frame", 8'(1 << i), SEGS_A[i], 1'b0);
        tick_chk("zero_wrap", 8'h01, 8'h3F, 1'b1);
        for (int i = 1; i < 4; i++)
            tick_chk("zero_frame", 8'(1 << i), 8'h3F, 1'b0);
        data = 32'h1234_5678;
        for (int i = 4; i < 8; i++)
            tick_chk("zero_hold", 8'(1 << i), 8'h3F, 1'b0);
        tick_chk("new_wrap", 8'h01, SEGS_B[0], 1'b1);
        for (int i = 1; i < 8; i++)
            tick_chk("frame_b", 8'(1 << i), SEGS_B[i], 1'b0);

        // Leading-zero blanking with a decimal point on a blanked digit.
        blank_lz = 1'b1; data = 32'h0000_0050; dp_en = 8'h04;
        tick_chk("lz_wrap", 8'h01, SEGS_C[0], 1'b1);
        for (int i = 1; i < 8; i++)
            tick_chk("lz_frame", 8'(1 << i), SEGS_C[i], 1'b0);

        // Ticks on three consecutive cycles: gap restarts each time.
        push(8'h00, 8'h00, 1'b1);
        push(8'h00, 8'h00, 1'b0);
        push(8'h00, 8'h00, 1'b0);
        push(8'h00, 8'h00, 1'b0);
        push(8'h04, 8'h80, 1'b0);
        tick = 1'b1;
        @(posedge clk); #1;
        pop_chk("burst_e1");
        chk("burst_e1_nogap", {sel0, seg0, 7'd0, fd0}, {8'h01, 8'h3F, 7'd0, 1'b1});
        @(posedge clk); #1;
        pop_chk("burst_e2");
        chk("burst_e2_nogap", {sel0, seg0, 7'd0, fd0}, {8'h02, 8'h6D, 7'd0, 1'b0});
        @(posedge clk); #1;
        tick = 1'b0;
        pop_chk("burst_e3");
        chk("burst_e3_nogap", {sel0, seg0, 7'd0, fd0}, {8'h04, 8'h80, 7'd0, 1'b0});
        @(posedge clk); #1;
        pop_chk("burst_e4");
        @(posedge clk); #1;
        pop_chk("burst_e5");

        // Reset while digit 4 is lit.
        tick_chk("pre_rst3", 8'h08, 8'h00, 1'b0);
        tick_chk("pre_rst4", 8'h10, 8'h00, 1'b0);
        chk("before_rst_sel", 32'(sel), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        chk_dark("async_rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_dark("rst_held");
        end
        rst = 1'b0;
        data = 32'h7654_3210; dp_en = 8'h00; blank_lz = 1'b0;
        @(posedge clk); #1;
        chk_dark("post_rst_idle");
        tick_chk("restart0", 8'h01, 8'h3F, 1'b0);
        tick_chk("restart1", 8'h02, 8'h06, 1'b0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
